// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = 32'd4;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DROP  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Fetch buffer: registered push, head visible the cycle after push; flush beats pop.
// No internal backpressure -- the producer must gate pushes on count/full.
module ifetch_fifo #(
   parameter int  DEPTH = 2,
   parameter type T     = logic [63:0],
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push,
   input  T              push_data,
   input  logic          pop,
   input  logic          flush,
   output T              head,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   T               mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (pop) rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/ifetch_stage.sv
// Fetch stage: one outstanding icache request, result on instr_* one cycle after ack; stops
// requesting while the buffer is full. Define IFETCH_PERF_EN to enable fetch/stall counters.
module ifetch_stage
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        icache_req_o,
   output logic [31:0] icache_addr_o,
   input  logic        icache_ack_i,
   input  logic [31:0] icache_data_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o
);

   localparam int          CW       = $clog2(BUF_DEPTH + 1);
   localparam logic [0:0]  ST_FETCH = 1'(FETCH);
   localparam logic [0:0]  ST_DROP  = 1'(DROP);

   logic [0:0]      state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] old_pc;
   logic            active;
   logic            ack;
   logic            push;
   logic            pop;
   fetch_entry_t    head;
   logic [CW-1:0]   count;
   logic            empty;
   logic            full;

   // active keeps req low for the first cycle out of reset.
   assign icache_req_o  = active && ((state == ST_DROP) || (count < CW'(BUF_DEPTH)));
   assign icache_addr_o = (state == ST_DROP) ? old_pc : pc;
   assign ack           = icache_req_o && icache_ack_i;
   assign push          = (state == ST_FETCH) && ack && !redirect_i;
   assign pop           = instr_valid_o && instr_ready_i;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= ST_FETCH;
         pc     <= align_pc(RESET_PC);
         old_pc <= align_pc(RESET_PC);
         active <= 1'b0;
      end else begin
         active <= 1'b1;
         if (state == ST_FETCH) begin
            if (redirect_i) begin
               pc <= align_pc(redirect_pc_i);
               // The in-flight request must still complete at its original address.
               if (icache_req_o && !icache_ack_i) begin
                  old_pc <= pc;
                  state  <= ST_DROP;
               end
            end else if (ack) begin
               pc <= pc + PC_STEP;
            end
         end else begin
            if (redirect_i) pc <= align_pc(redirect_pc_i);
            if (ack) state <= ST_FETCH;
         end
      end
   end

   ifetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data ('{pc: pc, instr: icache_data_i}),
      .pop       (pop),
      .flush     (redirect_i),
      .head      (head),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   assign instr_valid_o = !empty;
   assign instr_o       = head.instr;
   assign instr_pc_o    = head.pc;

   assert property (@(posedge clk) disable iff (!reset_n) !(push && full));

`ifdef IFETCH_PERF_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (push) fetch_cnt <= fetch_cnt + 32'd1;
         if (icache_req_o && !icache_ack_i) stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign fetch_cnt_o = fetch_cnt;
   assign stall_cnt_o = stall_cnt;
`else
   assign fetch_cnt_o = '0;
   assign stall_cnt_o = '0;
`endif

endmodule
